// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Number of cycles D/E are flushed after reset release.
  localparam logic [1:0] INIT_FLUSH_CYCLES = 2'd2;

  // True when a later stage will write the register the operand reads (x0 never matches).
  function automatic logic reg_match(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake between the hazard controller and memory.
interface hazard_ctrl_if;

  logic mem_req;
  logic mem_ack;

  modport master (output mem_req, input mem_ack);
  modport slave  (input mem_req, output mem_ack);

endinterface

// File: rtl/fwd_sel.sv
// Execute-stage forwarding select for one operand; M result wins over W result.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_e   sel
);

  // Priority select: newest producer first.
  always_comb begin
    sel = FWD_RF;
    if (reg_match(reg_write_m, rd_m, rs)) begin
      sel = FWD_MEM;
    end else if (reg_match(reg_write_w, rd_w, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, forwarding selects, data-memory
// handshake sequencing with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned PERF_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_ctrl_if.master       mem,
  input  logic [4:0]          Rs1D,
  input  logic [4:0]          Rs2D,
  input  logic [4:0]          Rs1E,
  input  logic [4:0]          Rs2E,
  input  logic [4:0]          RdE,
  input  logic [4:0]          RdM,
  input  logic [4:0]          RdW,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic [1:0]          ResultSrcE,
  input  logic                PCSrcE,
  input  logic                MemAccessM,
  output logic                StallF,
  output logic                StallD,
  output logic                StallE,
  output logic                StallM,
  output logic                FlushD,
  output logic                FlushE,
  output logic                FlushW,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                mem_timeout,
  output logic [PERF_W-1:0]   stall_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       init_q;
  logic [PERF_W-1:0] perf_q;

  logic     mem_req;
  logic     mem_stall;
  logic     lw_stall;
  fwd_sel_e fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  // Memory FSM next state and wait counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (MemAccessM && !mem.mem_ack) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
        end else if (wait_q == WaitLast) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Handshake and hazard detection; rst_n gates them so reset holds everything quiet.
  always_comb begin
    mem_req   = rst_n && (((state_q == IDLE) && MemAccessM) || (state_q == WAIT));
    mem_stall = rst_n && ((mem_req && !mem.mem_ack) || (state_q == ERR));
    lw_stall  = rst_n && (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
  end

  assign mem.mem_req  = mem_req;
  assign mem_timeout  = (state_q == ERR);

  // Stall/flush selection; a memory stall freezes E so branch and load-use wait it out.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (rst_n) begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
    if (init_q != 2'd0) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Post-reset flush countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= INIT_FLUSH_CYCLES;
    end else if (init_q != 2'd0) begin
      init_q <= init_q - 2'd1;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (StallF && (perf_q != {PERF_W{1'b1}})) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign stall_count = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based scoreboard checked on the falling edge.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned PERF_W  = 4;

  logic clk;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MemAccessM;
  logic [1:0] ResultSrcE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [PERF_W-1:0] stall_count;

  hazard_ctrl_if mem_bus ();

  hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mem_bus),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE  (ResultSrcE),
    .PCSrcE      (PCSrcE),
    .MemAccessM  (MemAccessM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM}, {FlushD,FlushE,FlushW}, fwd A, fwd B, mem_req, timeout, count
  typedef struct packed {
    logic [3:0]        stall;
    logic [2:0]        flush;
    logic [1:0]        fa;
    logic [1:0]        fb;
    logic              req;
    logic              tmo;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [PERF_W-1:0] exp_cnt = '0;

  // Scoreboard: compare the oldest pending expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{stall: {StallF, StallD, StallE, StallM}, flush: {FlushD, FlushE, FlushW},
            fa: ForwardAE, fb: ForwardBE, req: mem_bus.mem_req, tmo: mem_timeout,
            cnt: stall_count};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed stall=%b flush=%b fa=%b fb=%b req=%b tmo=%b cnt=%0d required stall=%b flush=%b fa=%b fb=%b req=%b tmo=%b cnt=%0d",
               t, o.stall, o.flush, o.fa, o.fb, o.req, o.tmo, o.cnt,
               e.stall, e.flush, e.fa, e.fb, e.req, e.tmo, e.cnt);
      end
    end
  end

  // Queue one cycle of expectations for the inputs just driven, then advance a cycle.
  task automatic step(input string tag, input logic [3:0] st, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic req,
                      input logic tmo);
    exp_t e;
    e = '{stall: st, flush: fl, fa: fa, fb: fb, req: req, tmo: tmo, cnt: exp_cnt};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (st[3] && rst_n && (exp_cnt != {PERF_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; MemAccessM = 1'b0; mem_bus.mem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    MemAccessM = 1'b1;
    @(posedge clk);
    #1;
    // Reset held: D/E flushed, no request even with a pending access.
    step("rst_hold0", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("rst_hold1", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    MemAccessM = 1'b0;
    rst_n = 1'b1;
    step("init_flush0", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("init_flush1", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("init_done", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Forwarding priorities and x0 suppression.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    step("fwd_mem_prio", 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0);
    RegWriteM = 1'b0;
    step("fwd_wb", 4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0);
    Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1;
    step("fwd_b_mem_a_wb", 4'b0000, 3'b000, 2'b01, 2'b10, 1'b0, 1'b0);
    RegWriteM = 1'b0; Rs2E = 5'd0; RdW = 5'd0; RegWriteW = 1'b1;
    step("fwd_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    idle_inputs();

    // Load-use, x0 load, branch, branch with load-use.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    step("load_use", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
    RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
    step("load_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    ResultSrcE = 2'b00; PCSrcE = 1'b1;
    step("branch", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    step("branch_load_use", 4'b1100, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    idle_inputs();

    // Memory wait: three cycles without ack, release on ack.
    MemAccessM = 1'b1;
    step("mem_wait0", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    step("mem_wait1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    step("mem_wait2", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    mem_bus.mem_ack = 1'b1;
    step("mem_ack", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
    MemAccessM = 1'b0; mem_bus.mem_ack = 1'b0;
    step("mem_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Zero-wait ack: request without stall.
    MemAccessM = 1'b1; mem_bus.mem_ack = 1'b1;
    step("mem_zero_wait", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
    MemAccessM = 1'b0; mem_bus.mem_ack = 1'b0;
    step("mem_zero_after", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Branch held in E across a memory stall, acted on once released.
    MemAccessM = 1'b1; PCSrcE = 1'b1;
    ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4;
    step("stall_branch0", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    ResultSrcE = 2'b00;
    step("stall_branch1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    mem_bus.mem_ack = 1'b1;
    step("branch_after_ack", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b1, 1'b0);
    idle_inputs();
    step("branch_done", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Timeout: one IDLE request cycle, TIMEOUT wait cycles, then sticky error.
    MemAccessM = 1'b1;
    step("to_idle", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      step($sformatf("to_wait%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 3) mem_bus.mem_ack = 1'b1;
      step($sformatf("to_err%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1);
    end

    // Reset pulse clears error and counter.
    rst_n = 1'b0;
    exp_cnt = '0;
    step("err_reset", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    step("re_init0", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("re_init1", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("re_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset mid-WAIT returns to IDLE; a late ack is ignored.
    MemAccessM = 1'b1;
    step("mid_wait0", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    step("mid_wait1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b0;
    MemAccessM = 1'b0;
    exp_cnt = '0;
    step("mid_wait_rst", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    mem_bus.mem_ack = 1'b1;
    step("late_ack0", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    mem_bus.mem_ack = 1'b0;
    step("late_ack1", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);
    step("late_ack_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Drain the scoreboard.
    @(negedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the decode/execute/memory/writeback datapath and produces the per-stage stall and flush controls and the execute-stage forwarding selects. It also sequences the data-memory request/acknowledge handshake, freezing the pipeline while a memory access is outstanding. It flags a memory timeout and counts stall cycles for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 64, max cycles a memory request may wait for ack before error (≥2)
- PERF_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs in E
- RdM, RdW  in  5  dest regs in M, W
- RegWriteM, RegWriteW  in  1  write enables in M, W
- ResultSrcE  in  2  result source in E; 2'b01 = load
- PCSrcE  in  1  taken branch or jump resolved in E
- MemAccessM  in  1  instruction in M is a load or store
- mem_ack  in  1  data memory acknowledge
- mem_req  out  1  data memory request
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  load bubble into stage register
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- mem_timeout  out  1  sticky timeout error
- stall_count  out  PERF_W  saturating count of cycles with StallF=1

## Operation
- Forwarding, per operand X∈{1,2}: 10 if RegWriteM & RdM≠0 & RdM==RsXE; else 01 if RegWriteW & RdW≠0 & RdW==RsXE; else 00. M has priority over W.
- Load-use: lw_stall = ResultSrcE==01 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Memory FSM states: IDLE, WAIT, ERR.
  - mem_req = (IDLE & MemAccessM) | WAIT.
  - IDLE→WAIT when MemAccessM & !mem_ack.
  - WAIT→IDLE on mem_ack.
  - WAIT→ERR when wait counter reaches TIMEOUT-1 without ack.
  - ERR is absorbing until reset. In ERR, mem_req=0 and mem_timeout=1.
- mem_stall = (mem_req & !mem_ack) | ERR. A zero-wait ack in the same cycle as the request produces no stall.
- Outputs with mem_stall=1:
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1.
  - FlushD = FlushE = 0. Load-use and PCSrcE are ignored; the E stage is frozen, so PCSrcE is re-presented and acted on after the stall.
- Outputs with mem_stall=0:
  - StallF = StallD = lw_stall; StallE = StallM = 0.
  - FlushD = PCSrcE.
  - FlushE = lw_stall | PCSrcE.
  - FlushW = 0.
- Init flush: a 2-bit counter loads 2 at reset and decrements to 0. While it is nonzero, FlushD = FlushE = 1, overriding everything else.
- stall_count increments each cycle StallF=1 and saturates at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs, FSM state and the init counter. There is no added latency.
- While rst_n is low:
  - FSM = IDLE; wait counter = 0; init counter = 2.
  - stall_count = 0; mem_timeout = 0; mem_req = 0.
  - FlushD = FlushE = 1; all stalls and FlushW = 0.
- The first 2 cycles after reset release flush D/E.
- The wait counter clears on entry to WAIT and increments each WAIT cycle. ERR is entered on the edge after TIMEOUT WAIT cycles.
- Reset asserted mid-WAIT returns immediately to IDLE. A late mem_ack after reset is ignored.
- PCSrcE together with lw_stall: FlushD and FlushE assert; StallF and StallD also assert. The F/D contents are flushed, so no wrong-path instruction commits.

## Structure
- Shared package hazard_pkg holds:
  - fwd_sel_e: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - mem_state_e: IDLE, WAIT, ERR.
  - RESULT_SRC_LOAD = 2'b01.
- Sub-module fwd_sel (combinational, one operand) is instantiated twice, once for A and once for B.
- The FSM, wait counter, init counter and perf counter live in hazard_ctrl.

## Test plan
- Reset, then idle inputs: FlushD=FlushE=1 for exactly 2 cycles after release, then 0. stall_count=0.
- Forwarding:
  - RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5: ForwardAE=10.
  - Drop RegWriteM: ForwardAE=01.
  - Rs2E=0 with RdW=0, RegWriteW=1: ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle. stall_count +1.
- Memory wait: MemAccessM=1, mem_ack low for 3 cycles then high → mem_req high for 4 cycles. All stalls and FlushW=1 for 3 cycles. Release on the ack cycle.
- Timeout with TIMEOUT=4, ack never asserted: mem_timeout=1 after 4 WAIT cycles. mem_req=0 and stalls remain 1. rst_n pulse clears all.
- Memory stall with PCSrcE=1: FlushD/FlushE stay 0 during the stall and both assert on the first cycle after ack.
